// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, data width and frame-length constants.
// Parity support is selected by the UART_OUT_PARITY_EN macro.
package uart_pkg;

  localparam int DATA_BITS       = 8;
  localparam int DEFAULT_CLK_DIV = 868;

`ifdef UART_OUT_PARITY_EN
  localparam int FRAME_BITS = DATA_BITS + 3;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
`else
  localparam int FRAME_BITS = DATA_BITS + 2;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
`endif

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered occupancy count; DEPTH must be a power of two.
// Pushes while full and pops while empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             push_ok, pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

  // Storage needs no reset: the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_out_port.sv
// OUT-instruction responder: buffers core bytes in a FIFO and sends each as a UART frame on TXD.
// Define UART_OUT_PARITY_EN for 8E1 frames; default build is 8N1.
module uart_out_port
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = DEFAULT_CLK_DIV,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       OUT_VALID,
  input  logic [7:0] OUT_DATA,
  output logic       OUT_READY,
  output logic       TXD,
  output logic       BUSY
);

  localparam logic [15:0] BAUD_LAST = 16'(CLK_DIV - 1);
  localparam logic [2:0]  BIT_LAST  = 3'(DATA_BITS - 1);

  tx_state_t      state, state_nxt;
  logic [15:0]    baud_cnt;
  logic [2:0]     bit_cnt;
  logic [7:0]     shift;
  logic [7:0]     fifo_dout;
  logic           fifo_full, fifo_empty;
  logic           push, pop, bit_end;
`ifdef UART_OUT_PARITY_EN
  logic           parity;
`endif

  assign OUT_READY = !fifo_full;
  assign push      = OUT_VALID && OUT_READY;
  assign bit_end   = (baud_cnt == BAUD_LAST);
  assign BUSY      = (state != IDLE) || !fifo_empty;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (CLK),
    .rst_n (RST_N),
    .push  (push),
    .pop   (pop),
    .din   (OUT_DATA),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nxt;
  end

  // TXD decodes from state, so an async reset forces the line high immediately.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    TXD       = 1'b1;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = START;
        end
      end
      START: begin
        TXD = 1'b0;
        if (bit_end) state_nxt = DATA;
      end
      DATA: begin
        TXD = shift[0];
`ifdef UART_OUT_PARITY_EN
        if (bit_end && bit_cnt == BIT_LAST) state_nxt = PARITY;
      end
      PARITY: begin
        TXD = parity;
        if (bit_end) state_nxt = STOP;
`else
        if (bit_end && bit_cnt == BIT_LAST) state_nxt = STOP;
`endif
      end
      STOP: begin
        if (bit_end) begin
          if (!fifo_empty) begin
            pop       = 1'b1;
            state_nxt = START;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
`ifdef UART_OUT_PARITY_EN
      parity   <= 1'b0;
`endif
    end else if (pop) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= fifo_dout;
`ifdef UART_OUT_PARITY_EN
      parity   <= ^fifo_dout;
`endif
    end else if (state != IDLE) begin
      baud_cnt <= bit_end ? '0 : baud_cnt + 16'd1;
      if (state == DATA && bit_end) begin
        shift   <= {1'b0, shift[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
    end
  end

endmodule
